// File: rtl/usb_rx_decode.sv
// USB full-speed receive front end: line synchronizer, bit-timing recovery, NRZI decode, stuff and EOP detection.
// Define USB_RX_DECODE_BIT_ERROR_EN to compile in stuff-bit violation reporting on bit_error.
module usb_rx_decode #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic d_plus,
   input  logic d_minus,
   input  logic rx_enable,
   output logic d_orig,
   output logic shift_enable,
   output logic stuff_bit,
   output logic eop,
   output logic bit_error
);

   localparam logic [3:0] CNT_LAST   = 4'(CLKS_PER_BIT - 1);
   localparam logic [3:0] CNT_SAMPLE = 4'(SAMPLE_POINT);

   logic       dp_m, dp_s, dm_m, dm_s, dp_q;
   logic [3:0] cnt;
   logic       dp_edge, strobe, rx_bit;
   logic [2:0] ones, ones_n;
   logic [1:0] se0_cnt, se0_n;
   logic       last_dp, last_dp_n;
   logic       d_orig_n, shift_n, stuff_n, eop_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         dp_m <= 1'b1;
         dp_s <= 1'b1;
         dm_m <= 1'b0;
         dm_s <= 1'b0;
         dp_q <= 1'b1;
      end else begin
         dp_m <= d_plus;
         dp_s <= dp_m;
         dm_m <= d_minus;
         dm_s <= dm_m;
         dp_q <= dp_s;
      end
   end

   assign dp_edge = (dp_s != dp_q);
   assign strobe  = (cnt == CNT_SAMPLE) && rx_enable;
   assign rx_bit  = (dp_s == last_dp);

   // Any D+ transition re-centres the bit timer, so a slightly long or short bit still gets one strobe.
   always_ff @(posedge clk) begin
      if (rst || !rx_enable || dp_edge)
         cnt <= 4'd0;
      else if (cnt == CNT_LAST)
         cnt <= 4'd0;
      else
         cnt <= cnt + 4'd1;
   end

`ifdef USB_RX_DECODE_BIT_ERROR_EN
   logic berr_n;
`endif

   always_comb begin
      ones_n    = ones;
      se0_n     = se0_cnt;
      last_dp_n = last_dp;
      d_orig_n  = d_orig;
      shift_n   = 1'b0;
      stuff_n   = 1'b0;
      eop_n     = 1'b0;
`ifdef USB_RX_DECODE_BIT_ERROR_EN
      berr_n    = 1'b0;
`endif
      if (!rx_enable) begin
         ones_n    = 3'd0;
         se0_n     = 2'd0;
         last_dp_n = 1'b1;
      end else if (strobe) begin
         if (!dp_s && !dm_s) begin
            if (se0_cnt != 2'd2)
               se0_n = se0_cnt + 2'd1;
         end else if (se0_cnt == 2'd2) begin
            eop_n     = 1'b1;
            se0_n     = 2'd0;
            ones_n    = 3'd0;
            last_dp_n = 1'b1;
         end else begin
            se0_n     = 2'd0;
            last_dp_n = dp_s;
            d_orig_n  = rx_bit;
            shift_n   = 1'b1;
            // After six ones the next bit is the stuffed zero; it is still shifted out and dropped downstream.
            if (ones == 3'd6) begin
               ones_n = 3'd0;
`ifdef USB_RX_DECODE_BIT_ERROR_EN
               berr_n = rx_bit;
`endif
            end else if (rx_bit) begin
               ones_n  = ones + 3'd1;
               stuff_n = (ones == 3'd5);
            end else begin
               ones_n = 3'd0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ones         <= 3'd0;
         se0_cnt      <= 2'd0;
         last_dp      <= 1'b1;
         d_orig       <= 1'b1;
         shift_enable <= 1'b0;
         stuff_bit    <= 1'b0;
         eop          <= 1'b0;
      end else begin
         ones         <= ones_n;
         se0_cnt      <= se0_n;
         last_dp      <= last_dp_n;
         d_orig       <= d_orig_n;
         shift_enable <= shift_n;
         stuff_bit    <= stuff_n;
         eop          <= eop_n;
      end
   end

`ifdef USB_RX_DECODE_BIT_ERROR_EN
   always_ff @(posedge clk) begin
      if (rst)
         bit_error <= 1'b0;
      else
         bit_error <= berr_n;
   end
`else
   assign bit_error = 1'b0;
`endif

endmodule
